// File: rtl/modp_pkg.sv
// Shared constants and types for the GF(2^255 - 19) arithmetic blocks.
package modp_pkg;

  localparam int N = 255;

  // 2^255 - 19: all ones in N bits, minus 18
  localparam logic [N-1:0] P = {N{1'b1}} - 255'd18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/modp_dbl_add.sv
// Single double-and-add step: (2*acc + add_bit*a) mod P, with acc, a < P.
module modp_dbl_add
  import modp_pkg::*;
(
  input  logic [N-1:0] acc,
  input  logic [N-1:0] a,
  input  logic         add_bit,
  output logic [N-1:0] res
);

  localparam logic [N:0] P_EXT = {1'b0, P};

  logic [N:0] dbl_s;
  logic [N:0] sum_s;

  // Double then reduce once; the result stays below 2P so one subtract suffices.
  always_comb begin
    dbl_s = {acc, 1'b0};
    if (dbl_s >= P_EXT) begin
      dbl_s = dbl_s - P_EXT;
    end else begin
      dbl_s = dbl_s;
    end
    if (add_bit) begin
      sum_s = dbl_s + {1'b0, a};
    end else begin
      sum_s = dbl_s;
    end
    if (sum_s >= P_EXT) begin
      sum_s = sum_s - P_EXT;
    end else begin
      sum_s = sum_s;
    end
    res = sum_s[N-1:0];
  end

endmodule

// File: rtl/mul_modp_seq.sv
// Sequential MSB-first interleaved modular multiplier, one multiplier bit per cycle.
module mul_modp_seq
  import modp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] prod
);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] acc_q, acc_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [N-1:0] prod_q, prod_d;
  logic [N-1:0] step_s;

  modp_dbl_add u_step (
    .acc     (acc_q),
    .a       (a_q),
    .add_bit (b_q[cnt_q]),
    .res     (step_s)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Next-state logic: accept in IDLE, run exactly N steps, wait for consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: canonicalise x on accept, one double-and-add per RUN cycle.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // x < 2^N < 2P, so a single conditional subtract makes it canonical
          if (x >= P) begin
            a_d = x - P;
          end else begin
            a_d = x;
          end
          b_d   = y;
          acc_d = '0;
          cnt_d = 8'(N - 1);
        end else begin
          a_d = a_q;
        end
      end
      RUN: begin
        acc_d = step_s;
        if (cnt_q == 8'd0) begin
          prod_d = step_s;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        prod_d = prod_q;
      end
      default: begin
        acc_d = '0;
      end
    endcase
  end

  // Handshake outputs decoded directly from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     in_ready  = 1'b0;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign prod = prod_q;

endmodule
